// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver data width, FIFO control state encodings
// and the default FIFO depth.
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int UART_FIFO_DEPTH_LOG2 = 4;

   typedef enum logic [1:0] {
      FIFO_EMPTY   = 2'd0,
      FIFO_PARTIAL = 2'd1,
      FIFO_FULL    = 2'd2
   } fifo_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module uart_fifo_mem #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [DATA_W-1:0]     o_rdata
);

   logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver with a show-ahead valid/ready read
// side and a sticky overflow flag. Define UART_RX_FIFO_AFULL_EN to add the o_afull output.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W     = UART_DATA_W,
   parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
`ifdef UART_RX_FIFO_AFULL_EN
 , parameter int AFULL_THRESH = 12
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_strobe,
   input  logic [DATA_W-1:0]     i_wr_data,
   output logic                  o_rd_valid,
   output logic [DATA_W-1:0]     o_rd_data,
   input  logic                  i_rd_ready,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_overflow,
`ifdef UART_RX_FIFO_AFULL_EN
   output logic                  o_afull,
`endif
   input  logic                  i_ovf_clr
);

   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2**DEPTH_LOG2;

   fifo_state_e       state_q, state_d;
   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
   logic              strobe_q, ovf_q, ovf_d;
   logic              wr_pulse, push, pop, full, empty;
   logic [DATA_W-1:0] mem_rdata;

   // One push per strobe assertion, however long the receiver holds it high.
   assign wr_pulse = i_wr_strobe & ~strobe_q;
   assign full     = (state_q == FIFO_FULL);
   assign empty    = (state_q == FIFO_EMPTY);
   assign pop      = ~empty & i_rd_ready;
   // A pop on a full FIFO frees the slot this cycle, so the push still lands.
   assign push     = wr_pulse & (~full | pop);
   assign count    = wr_ptr_q - rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + CNT_W'(push);
      rd_ptr_d = rd_ptr_q + CNT_W'(pop);
      ovf_d    = ovf_q;
      if (wr_pulse && !push) ovf_d = 1'b1;
      else if (i_ovf_clr)    ovf_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FIFO_EMPTY:   if (push) state_d = FIFO_PARTIAL;
         FIFO_PARTIAL: begin
            if (push && !pop && count == CNT_W'(DEPTH - 1))  state_d = FIFO_FULL;
            else if (pop && !push && count == CNT_W'(1))     state_d = FIFO_EMPTY;
         end
         FIFO_FULL:    if (pop && !push) state_d = FIFO_PARTIAL;
         default:      state_d = FIFO_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FIFO_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         strobe_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         strobe_q <= i_wr_strobe;
         ovf_q    <= ovf_d;
      end
   end

   uart_fifo_mem #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk     (clk),
      .i_we    (push),
      .i_waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
      .i_wdata (i_wr_data),
      .i_raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
      .o_rdata (mem_rdata)
   );

   assign o_rd_valid = ~empty;
   assign o_rd_data  = empty ? '0 : mem_rdata;
   assign o_full     = full;
   assign o_empty    = empty;
   assign o_count    = count;
   assign o_overflow = ovf_q;

`ifdef UART_RX_FIFO_AFULL_EN
   logic             afull_q, afull_d;
   logic [CNT_W-1:0] count_d;

   // Computed from next-cycle pointers so it lines up with o_count.
   always_comb begin
      count_d = wr_ptr_d - rd_ptr_d;
      afull_d = (count_d >= CNT_W'(AFULL_THRESH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) afull_q <= 1'b0;
      else        afull_q <= afull_d;
   end

   assign o_afull = afull_q;
`endif

   fsm_matches_ptrs: assert property (@(posedge clk) disable iff (!reset)
      (empty == (wr_ptr_q == rd_ptr_q)) &&
      (full  == ((wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]))));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus queue scoreboard.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_wr_strobe, i_rd_ready, i_ovf_clr;
   logic [7:0] i_wr_data;
   logic       o_rd_valid, o_full, o_empty, o_overflow;
   logic [7:0] o_rd_data;
   logic [4:0] o_count;
`ifdef UART_RX_FIFO_AFULL_EN
   logic       o_afull;
`endif

   int checks = 0;
   int failures = 0;

   logic [7:0] sb[$];
   logic       m_ovf = 1'b0;
   logic       prev_strobe = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .i_wr_strobe (i_wr_strobe),
      .i_wr_data   (i_wr_data),
      .o_rd_valid  (o_rd_valid),
      .o_rd_data   (o_rd_data),
      .i_rd_ready  (i_rd_ready),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
`ifdef UART_RX_FIFO_AFULL_EN
      .o_afull     (o_afull),
`endif
      .i_ovf_clr   (i_ovf_clr)
   );

   typedef struct {
      logic       s;
      logic [7:0] d;
      logic       r;
      logic       c;
      int         cnt;
      logic       emp;
      logic       ful;
      logic       ovf;
      logic [7:0] dat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(o_count), 32'(sb.size()));
      chk("empty", 32'(o_empty), 32'(sb.size() == 0));
      chk("full", 32'(o_full), 32'(sb.size() == 16));
      chk("valid", 32'(o_rd_valid), 32'(sb.size() != 0));
      chk("rd_data", 32'(o_rd_data), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_AFULL_EN
      chk("afull", 32'(o_afull), 32'(sb.size() >= 12));
`endif
   endtask

   // Drive one cycle, update the scoreboard for what the next edge must do, check after it.
   task automatic cycle(input logic s, input logic [7:0] d, input logic r, input logic c);
      logic pulse, acc;
      i_wr_strobe = s;
      i_wr_data   = d;
      i_rd_ready  = r;
      i_ovf_clr   = c;
      pulse = s & ~prev_strobe;
      if (r && sb.size() > 0) begin
         chk("pop_data", 32'(o_rd_data), 32'(sb[0]));
         chk("pop_not_ff", 32'(o_rd_data == 8'hFF), 32'(sb[0] == 8'hFF));
         void'(sb.pop_front());
      end
      acc = pulse && (sb.size() < 16);
      if (acc) sb.push_back(d);
      if (pulse && !acc) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      prev_strobe = s;
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic push_byte(input logic [7:0] d);
      cycle(1'b1, d, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5};
      vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5};
      vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'hA5};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h77};
      vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h77};
      vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};

      reset = 1'b0;
      i_wr_strobe = 1'b0;
      i_wr_data = 8'h00;
      i_rd_ready = 1'b0;
      i_ovf_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_state();
      reset = 1'b1;

      // Vector table: short push/pop mix, held strobe, pop while empty, push into empty.
      foreach (vecs[i]) begin
         cycle(vecs[i].s, vecs[i].d, vecs[i].r, vecs[i].c);
         chk("vec_count", 32'(o_count), 32'(vecs[i].cnt));
         chk("vec_empty", 32'(o_empty), 32'(vecs[i].emp));
         chk("vec_full", 32'(o_full), 32'(vecs[i].ful));
         chk("vec_ovf", 32'(o_overflow), 32'(vecs[i].ovf));
         chk("vec_data", 32'(o_rd_data), 32'(vecs[i].dat));
      end

      // Long strobe: one push only.
      for (int i = 0; i < 160; i++) begin
         cycle(1'b1, 8'hA5, 1'b0, 1'b0);
         if (i == 0) chk("long_first_data", 32'(o_rd_data), 32'hA5);
      end
      chk("long_count", 32'(o_count), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Fill, overflow with a same-cycle clear (set wins), then clear.
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      chk("fill_full", 32'(o_full), 32'd1);
      cycle(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("ovf_set_wins", 32'(o_overflow), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(o_overflow), 32'd0);

      // Full FIFO: push and pop together.
      cycle(1'b1, 8'h55, 1'b1, 1'b0);
      chk("fullpp_count", 32'(o_count), 32'd16);
      chk("fullpp_ovf", 32'(o_overflow), 32'd0);
      chk("fullpp_head", 32'(o_rd_data), 32'h01);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      while (sb.size() > 1) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("last_is_55", 32'(o_rd_data), 32'h55);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Pointer wrap with push/pop pairs.
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("wrap_empty", 32'(o_empty), 32'd1);

      // Asynchronous reset mid-cycle with 7 entries.
      for (int i = 0; i < 7; i++) push_byte(8'(8'h40 + i));
      chk("pre_reset_count", 32'(o_count), 32'd7);
      #2;
      reset = 1'b0;
      #1;
      chk("async_empty", 32'(o_empty), 32'd1);
      chk("async_count", 32'(o_count), 32'd0);
      chk("async_data", 32'(o_rd_data), 32'd0);
      sb.delete();
      m_ovf = 1'b0;
      prev_strobe = 1'b0;
      i_wr_strobe = 1'b1;
      i_wr_data = 8'h99;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(1'b1, 8'h99, 1'b0, 1'b0);
      chk("post_reset_push", 32'(o_rd_data), 32'h99);
      cycle(1'b1, 8'h99, 1'b0, 1'b0);
      chk("post_reset_once", 32'(o_count), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_RX_FIFO_AFULL_EN
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
         chk("afull_rise", 32'(o_afull), 32'(i == 11));
         cycle(1'b0, 8'h00, 1'b0, 1'b0);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("afull_fall", 32'(o_afull), 32'd0);
      while (sb.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
